// File: rtl/median_window_if.sv
// median_window_if: pixel-in / three-word-column-out handshake bundle for median_window_feeder
interface median_window_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] pix_data;
    logic [DATA_WIDTH-1:0] word0;
    logic [DATA_WIDTH-1:0] word1;
    logic [DATA_WIDTH-1:0] word2;
    logic pix_valid;
    logic pix_ready;
    logic out_valid;
    logic out_ready;
    logic frame_done;
    modport master (
        input pix_data, pix_valid, out_ready,
        output pix_ready, word0, word1, word2, out_valid, frame_done
    );
    modport slave (
        output pix_data, pix_valid, out_ready,
        input pix_ready, word0, word1, word2, out_valid, frame_done
    );
endinterface

// File: rtl/median_window_feeder.sv
// median_window_feeder: line-buffered vertical 3-pixel column source for median_filter
// MEDIAN_WINDOW_BORDER_EN: when defined, rows 0/1 emit top-border-replicated columns
module median_window_feeder #(
    parameter int DATA_WIDTH = 32,
    parameter int LINE_LEN = 8,
    parameter int NUM_LINES = 8
) (
    input logic clk,
    input logic rst,
    median_window_if.master bus
);
    localparam int CW = $clog2(LINE_LEN);
    localparam int RW = $clog2(NUM_LINES);
    typedef enum logic [1:0] {FILL0, FILL1, STREAM} state_t;
    state_t state;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [DATA_WIDTH-1:0] lb0 [LINE_LEN];
    logic [DATA_WIDTH-1:0] lb1 [LINE_LEN];
    logic [DATA_WIDTH-1:0] top0;
    logic [DATA_WIDTH-1:0] top1;
    logic accept;
    logic emit;
    logic last_col;
    logic last_row;
    assign bus.pix_ready = !bus.out_valid || bus.out_ready;
    assign accept = bus.pix_valid && bus.pix_ready;
    assign last_col = col == CW'(LINE_LEN - 1);
    assign last_row = row == RW'(NUM_LINES - 1);
`ifdef MEDIAN_WINDOW_BORDER_EN
    assign emit = accept;
    assign top0 = state == FILL0 ? bus.pix_data : state == FILL1 ? lb0[col] : lb1[col];
    assign top1 = state == FILL0 ? bus.pix_data : lb0[col];
`else
    assign emit = accept && state == STREAM;
    assign top0 = lb1[col];
    assign top1 = lb0[col];
`endif
    // Line buffers are never cleared: each row is rewritten before it is read.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[col] <= lb0[col];
            lb0[col] <= bus.pix_data;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL0;
            col <= '0;
            row <= '0;
            bus.out_valid <= 1'b0;
            bus.frame_done <= 1'b0;
            bus.word0 <= '0;
            bus.word1 <= '0;
            bus.word2 <= '0;
        end else begin
            if (accept) begin
                col <= last_col ? '0 : col + 1'b1;
                if (last_col) begin
                    row <= last_row ? '0 : row + 1'b1;
                    state <= state == FILL0 ? FILL1 : state == FILL1 ? STREAM : last_row ? FILL0 : STREAM;
                end
            end
            // A freshly loaded column wins over a same-cycle take.
            if (emit) begin
                bus.word0 <= top0;
                bus.word1 <= top1;
                bus.word2 <= bus.pix_data;
                bus.out_valid <= 1'b1;
                bus.frame_done <= last_col && last_row;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
                bus.frame_done <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_median_window_feeder.sv
// tb_median_window_feeder: frame-level model plus directed checks for median_window_feeder
`timescale 1ns/1ps
module tb_median_window_feeder;
    localparam int DW = 32;
    localparam int LL = 4;
    localparam int NL = 4;
    localparam int W3 = 3 * DW;
`ifdef MEDIAN_WINDOW_BORDER_EN
    localparam bit BORDER = 1'b1;
`else
    localparam bit BORDER = 1'b0;
`endif
    localparam int COLS = BORDER ? LL * NL : (NL - 2) * LL;
    localparam int OFF = BORDER ? 2 * LL : 0;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    logic [W3-1:0] got [$];
    logic got_fd [$];
    logic [W3-1:0] ref_q [$];
    median_window_if #(.DATA_WIDTH(DW)) bus ();
    median_window_feeder #(.DATA_WIDTH(DW), .LINE_LEN(LL), .NUM_LINES(NL)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;
    function automatic logic [W3-1:0] col3(input int a, input int b, input int c);
        return {DW'(a), DW'(b), DW'(c)};
    endfunction
    task automatic chk(input string name, input logic [W3-1:0] act, input logic [W3-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask
    // Frame model: remembers every accepted pixel by (row, col) and forms columns from rows above.
    logic [DW-1:0] img [NL][LL];
    logic [DW-1:0] mp;
    logic [W3-1:0] m_col = '0;
    logic m_valid = 1'b0;
    logic m_fd = 1'b0;
    int mr = 0;
    int mc = 0;
    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1'b0;
            m_fd = 1'b0;
            m_col = '0;
            mr = 0;
            mc = 0;
        end else if (bus.pix_valid && (!m_valid || bus.out_ready)) begin
            mp = bus.pix_data;
            img[mr][mc] = mp;
            if (mr >= 2 || BORDER) begin
                m_col = {mr >= 2 ? img[mr-2][mc] : mr == 1 ? img[0][mc] : mp,
                         mr >= 1 ? img[mr-1][mc] : mp, mp};
                m_valid = 1'b1;
                m_fd = mr == NL - 1 && mc == LL - 1;
            end else if (bus.out_ready) begin
                m_valid = 1'b0;
                m_fd = 1'b0;
            end
            if (mc == LL - 1) begin
                mc = 0;
                mr = mr == NL - 1 ? 0 : mr + 1;
            end else begin
                mc++;
            end
        end else if (bus.out_ready) begin
            m_valid = 1'b0;
            m_fd = 1'b0;
        end
    end
    always @(negedge clk) begin
        chk("out_valid", W3'(bus.out_valid), W3'(m_valid));
        chk("pix_ready", W3'(bus.pix_ready), W3'(!m_valid || bus.out_ready));
        chk("frame_done", W3'(bus.frame_done), W3'(m_fd));
        if (m_valid || rst) chk("column", {bus.word0, bus.word1, bus.word2}, m_col);
        if (bus.out_valid && bus.out_ready) begin
            got.push_back({bus.word0, bus.word1, bus.word2});
            got_fd.push_back(bus.frame_done);
        end
    end
    task automatic send(input int p);
        bit done;
        done = 1'b0;
        bus.pix_data = DW'(p);
        bus.pix_valid = 1'b1;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            done = bus.pix_ready;
            @(posedge clk);
            #1;
        end
        if (!done) begin
            failures++;
            $display("FAIL send_timeout pixel=%0h accepted=0 required=1", p);
        end
    endtask
    task automatic send_frame();
        for (int r = 0; r < NL; r++)
            for (int c = 0; c < LL; c++)
                send(r * 16 + c);
    endtask
    task automatic idle(input int n);
        bus.pix_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    function automatic int fd_count();
        int n;
        n = 0;
        foreach (got_fd[i]) n += int'(got_fd[i]);
        return n;
    endfunction
    initial begin
        int t0;
        bus.pix_data = '0;
        bus.pix_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", W3'(bus.out_valid), '0);
        chk("reset_words", {bus.word0, bus.word1, bus.word2}, '0);
        rst = 1'b0;
        // Test 1: single frame, consumer always ready
        got.delete();
        got_fd.delete();
        send_frame();
        idle(3);
        chk("t1_count", W3'(got.size()), W3'(COLS));
        chk("t1_first", got[0], BORDER ? col3(0, 0, 0) : col3(8'h00, 8'h10, 8'h20));
        chk("t1_last", got[COLS-1], col3(8'h13, 8'h23, 8'h33));
        chk("t1_last_fd", W3'(got_fd[COLS-1]), W3'(1));
        chk("t1_fd_count", W3'(fd_count()), W3'(1));
`ifdef MEDIAN_WINDOW_BORDER_EN
        chk("t5_row1_col2", got[6], col3(8'h02, 8'h02, 8'h12));
`endif
        ref_q = got;
        // Test 2: two frames back to back at full rate
        got.delete();
        got_fd.delete();
        t0 = int'($time);
        send_frame();
        send_frame();
        chk("t2_cycles", W3'((int'($time) - t0) / 10), W3'(2 * LL * NL));
        idle(3);
        chk("t2_count", W3'(got.size()), W3'(2 * COLS));
        chk("t2_second_first", got[COLS], got[0]);
        chk("t2_second_last", got[2*COLS-1], col3(8'h13, 8'h23, 8'h33));
        chk("t2_fd_count", W3'(fd_count()), W3'(2));
        // Test 3: consumer stalls for 3 cycles while {01,11,21} is presented
        got.delete();
        got_fd.delete();
        for (int i = 0; i <= 2 * LL + 1; i++) send((i / LL) * 16 + i % LL);
        bus.out_ready = 1'b0;
        bus.pix_data = DW'(8'h22);
        repeat (3) begin
            @(negedge clk);
            chk("t3_stall_ready", W3'(bus.pix_ready), '0);
            chk("t3_stall_words", {bus.word0, bus.word1, bus.word2}, col3(8'h01, 8'h11, 8'h21));
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        for (int i = 2 * LL + 2; i < LL * NL; i++) send((i / LL) * 16 + i % LL);
        idle(3);
        chk("t3_count", W3'(got.size()), W3'(COLS));
        chk("t3_held", got[OFF+1], col3(8'h01, 8'h11, 8'h21));
        chk("t3_next", got[OFF+2], col3(8'h02, 8'h12, 8'h22));
        // Test 4: reset mid-frame, then a fresh frame
        for (int i = 0; i < 10; i++) send((i / LL) * 16 + i % LL);
        bus.pix_valid = 1'b0;
        rst = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("t4_reset_out_valid", W3'(bus.out_valid), '0);
        end
        rst = 1'b0;
        got.delete();
        got_fd.delete();
        send_frame();
        idle(3);
        chk("t4_count", W3'(got.size()), W3'(COLS));
        chk("t4_first", got[0], BORDER ? col3(0, 0, 0) : col3(8'h00, 8'h10, 8'h20));
        // Test 6: gappy pixel stream, ready consumer
        got.delete();
        got_fd.delete();
        for (int i = 0; i < LL * NL; i++) begin
            idle($urandom_range(0, 2));
            send((i / LL) * 16 + i % LL);
        end
        idle(3);
        chk("t6_count", W3'(got.size()), W3'(ref_q.size()));
        foreach (ref_q[i]) chk("t6_seq", got[i], ref_q[i]);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog finished=0 required=1");
        $fatal(1, "watchdog");
    end
endmodule
